// File: rtl/stream_demux_1_4.sv
// ---------------------------------------------------------------------------
// stream_demux_1_4
//
// Packet-aware 1-to-4 stream demultiplexer. One upstream valid/ready stream
// is steered to one of four downstream channels. The destination is taken
// from sel on the first beat of a packet and then held until the beat that
// carries last. Every channel has a one-entry output register, so all
// downstream outputs come straight from flops.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   up_valid  upstream beat valid
//   up_ready  upstream beat accepted when up_valid & up_ready
//   up_data   upstream beat data (WIDTH bits)
//   up_last   final beat of the packet
//   sel       destination channel, sampled only on a packet's first beat
//   dn_valid  per-channel valid, bit i = channel i
//   dn_ready  per-channel ready
//   dn_data   channel i data on bits [i*WIDTH +: WIDTH]
//   dn_last   per-channel last flag
//   busy      a packet is in progress (LOCKED state)
//   pkt_cnt   channel i completed-packet count on bits [i*CNT_W +: CNT_W]
// ---------------------------------------------------------------------------
module stream_demux_1_4 #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 up_valid,
    output logic                 up_ready,
    input  logic [WIDTH-1:0]     up_data,
    input  logic                 up_last,
    input  logic [1:0]           sel,
    output logic [3:0]           dn_valid,
    input  logic [3:0]           dn_ready,
    output logic [4*WIDTH-1:0]   dn_data,
    output logic [3:0]           dn_last,
    output logic                 busy,
    output logic [4*CNT_W-1:0]   pkt_cnt
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       lockCh_q, lockCh_d;
    logic [1:0]       ch;
    logic             accept;

    logic [3:0]       dnValid_q, dnValid_d;
    logic [3:0]       dnLast_q, dnLast_d;
    logic [WIDTH-1:0] bufData_q [4];
    logic [WIDTH-1:0] bufData_d [4];
    logic [CNT_W-1:0] pktCnt_q [4];
    logic [CNT_W-1:0] pktCnt_d [4];

    // Active channel: a fresh packet follows sel, a packet in progress
    // follows the channel latched on its first beat. The ready path looks
    // only at that one channel's buffer, so a stalled channel never blocks
    // traffic bound elsewhere, and up_valid is deliberately not involved.
    always_comb begin
        ch       = (state_q == IDLE) ? sel : lockCh_q;
        up_ready = !rst && (!dnValid_q[ch] || dn_ready[ch]);
        accept   = up_valid && up_ready;
    end

    // Packet framing. A single-beat packet (last on the first beat) never
    // leaves IDLE; otherwise the channel is latched until the last beat.
    always_comb begin
        state_d  = state_q;
        lockCh_d = lockCh_q;
        unique case (state_q)
            IDLE: begin
                if (accept && !up_last) begin
                    state_d  = LOCKED;
                    lockCh_d = sel;
                end
            end
            LOCKED: begin
                if (accept && up_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-channel output buffers and packet counters. A load wins over a
    // drain on the same channel, which keeps valid high and gives one beat
    // per cycle when downstream is always ready. Counting happens at accept
    // time so the count does not wait on the downstream consumer.
    always_comb begin
        dnValid_d = dnValid_q;
        dnLast_d  = dnLast_q;
        bufData_d = bufData_q;
        pktCnt_d  = pktCnt_q;
        for (int i = 0; i < 4; i++) begin
            if (accept && (ch == 2'(i))) begin
                dnValid_d[i] = 1'b1;
                dnLast_d[i]  = up_last;
                bufData_d[i] = up_data;
                if (up_last) begin
                    pktCnt_d[i] = pktCnt_q[i] + CNT_W'(1);
                end
            end else if (dn_ready[i]) begin
                dnValid_d[i] = 1'b0;
            end
        end
    end

    // State registers. Reset drops any buffered beats and a partially
    // received packet without counting it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lockCh_q  <= 2'd0;
            dnValid_q <= 4'd0;
            dnLast_q  <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                bufData_q[i] <= '0;
                pktCnt_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            lockCh_q  <= lockCh_d;
            dnValid_q <= dnValid_d;
            dnLast_q  <= dnLast_d;
            for (int i = 0; i < 4; i++) begin
                bufData_q[i] <= bufData_d[i];
                pktCnt_q[i]  <= pktCnt_d[i];
            end
        end
    end

    // Flatten the per-channel registers onto the packed output buses.
    always_comb begin
        dn_data  = '0;
        pkt_cnt  = '0;
        dn_valid = dnValid_q;
        dn_last  = dnLast_q;
        busy     = (state_q == LOCKED);
        for (int i = 0; i < 4; i++) begin
            dn_data[i*WIDTH +: WIDTH] = bufData_q[i];
            pkt_cnt[i*CNT_W +: CNT_W] = pktCnt_q[i];
        end
    end

endmodule
